// File: rtl/expr_result_misr.sv
// Capture stage for the expression result bus: compacts N handshaked samples into a MISR signature.
// Optional macro EXPR_MISR_TIMEOUT_EN adds a 255-cycle idle timeout and a timeout output.
module expr_result_misr #(
  parameter int unsigned          DATA_W  = 20,
  parameter int unsigned          SIG_W   = 32,
  parameter int unsigned          COUNT_W = 16,
  parameter logic [SIG_W-1:0]     POLY    = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]     SEED    = 32'h00000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SIG_W-1:0]   sig_out,
  output logic               sig_valid,
  input  logic               sig_ack,
  output logic               busy,
  output logic [COUNT_W-1:0] sample_count
`ifdef EXPR_MISR_TIMEOUT_EN
  ,output logic              timeout
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [SIG_W-1:0]     r_sig;
  logic [COUNT_W-1:0]   r_count;
  logic [COUNT_W-1:0]   r_num;
  logic                 r_sig_valid;
  logic                 r_busy;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_start_ok;
  logic [SIG_W-1:0]     w_misr;

`ifdef EXPR_MISR_TIMEOUT_EN
  localparam int unsigned IDLE_W = 8;
  logic [IDLE_W-1:0]    r_idle;
  logic                 r_timeout;
  logic                 w_to_hit;
`endif

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_hs       = in_valid && (r_state == ST_COLLECT);
  assign w_last     = (r_count == (r_num - COUNT_W'(1)));
  // Shift with polynomial feedback, then fold in the zero-extended sample.
  assign w_misr     = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(in_data);

`ifdef EXPR_MISR_TIMEOUT_EN
  assign w_to_hit   = (r_state == ST_COLLECT) && !w_hs && (r_idle == IDLE_W'(254));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = (num_samples != '0) ? ST_COLLECT : ST_DONE;
      end
      ST_COLLECT: begin
        if (w_hs && w_last) w_next_state = ST_DONE;
`ifdef EXPR_MISR_TIMEOUT_EN
        else if (w_to_hit) w_next_state = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (sig_ack) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: only in_ready is combinational
  always_comb begin
    in_ready = 1'b0;
    if (r_state == ST_COLLECT) in_ready = 1'b1;
  end

  // Signature, counters and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig       <= SEED;
      r_count     <= '0;
      r_num       <= '0;
      r_sig_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sig_valid <= (w_next_state == ST_DONE);
      r_busy      <= (w_next_state != ST_IDLE);
      if (w_start_ok) begin
        r_sig   <= SEED;
        r_count <= '0;
        if (num_samples != '0) r_num <= num_samples;
      end else if (w_hs) begin
        r_sig   <= w_misr;
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

`ifdef EXPR_MISR_TIMEOUT_EN
  // Idle watchdog: counts COLLECT cycles without a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start_ok || w_hs)          r_idle <= '0;
      else if (r_state == ST_COLLECT)  r_idle <= r_idle + IDLE_W'(1);
      if (w_to_hit)                              r_timeout <= 1'b1;
      else if ((r_state == ST_DONE) && sig_ack)  r_timeout <= 1'b0;
    end
  end

  assign timeout = r_timeout;
`endif

  assign sig_out      = r_sig;
  assign sig_valid    = r_sig_valid;
  assign busy         = r_busy;
  assign sample_count = r_count;

endmodule

// File: tb/tb_expr_result_misr.sv
// Self-checking bench for expr_result_misr: per-cycle model compare on two seeds plus directed literals.
module tb_expr_result_misr;

  localparam logic [31:0] SEED_A = 32'h00000000;
  localparam logic [31:0] SEED_B = 32'h80000000;
  localparam logic [31:0] POLY   = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic [19:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        sig_ack = 1'b0;

  logic        a_in_ready, a_sig_valid, a_busy;
  logic [31:0] a_sig_out;
  logic [15:0] a_sample_count;
  logic        b_in_ready, b_sig_valid, b_busy;
  logic [31:0] b_sig_out;
  logic [15:0] b_sample_count;
`ifdef EXPR_MISR_TIMEOUT_EN
  logic        a_timeout, b_timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  expr_result_misr u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .sig_out(a_sig_out), .sig_valid(a_sig_valid), .sig_ack(sig_ack),
    .busy(a_busy), .sample_count(a_sample_count)
`ifdef EXPR_MISR_TIMEOUT_EN
    , .timeout(a_timeout)
`endif
  );

  expr_result_misr #(.SEED(SEED_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .sig_out(b_sig_out), .sig_valid(b_sig_valid), .sig_ack(sig_ack),
    .busy(b_busy), .sample_count(b_sample_count)
`ifdef EXPR_MISR_TIMEOUT_EN
    , .timeout(b_timeout)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [19:0] d);
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ {12'h000, d};
  endfunction

  // Reference model: run phase 0=idle, 1=collecting, 2=signature presented
  int          m_phase;
  int          m_idle;
  logic [31:0] m_sig_a, m_sig_b;
  logic [15:0] m_cnt, m_num;
  logic        m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_idle <= 0; m_sig_a <= SEED_A; m_sig_b <= SEED_B;
      m_cnt <= '0; m_num <= '0; m_to <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_sig_a <= SEED_A; m_sig_b <= SEED_B; m_cnt <= '0; m_idle <= 0;
          if (num_samples != 0) begin m_num <= num_samples; m_phase <= 1; end
          else m_phase <= 2;
        end
        1: if (in_valid) begin
          m_sig_a <= misr(m_sig_a, in_data);
          m_sig_b <= misr(m_sig_b, in_data);
          m_cnt   <= m_cnt + 16'd1;
          m_idle  <= 0;
          if (int'(m_cnt) + 1 == int'(m_num)) m_phase <= 2;
        end else begin
`ifdef EXPR_MISR_TIMEOUT_EN
          if (m_idle + 1 >= 255) begin m_phase <= 2; m_to <= 1'b1; end
`endif
          m_idle <= m_idle + 1;
        end
        default: if (sig_ack) begin m_phase <= 0; m_to <= 1'b0; end
      endcase
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    chk("a_in_ready",  {31'h0, a_in_ready},  {31'h0, m_phase == 1});
    chk("a_sig_valid", {31'h0, a_sig_valid}, {31'h0, m_phase == 2});
    chk("a_busy",      {31'h0, a_busy},      {31'h0, m_phase != 0});
    chk("a_sig_out",   a_sig_out,            m_sig_a);
    chk("a_count",     {16'h0, a_sample_count}, {16'h0, m_cnt});
    chk("b_in_ready",  {31'h0, b_in_ready},  {31'h0, m_phase == 1});
    chk("b_sig_valid", {31'h0, b_sig_valid}, {31'h0, m_phase == 2});
    chk("b_sig_out",   b_sig_out,            m_sig_b);
    chk("b_count",     {16'h0, b_sample_count}, {16'h0, m_cnt});
`ifdef EXPR_MISR_TIMEOUT_EN
    chk("a_timeout",   {31'h0, a_timeout},   {31'h0, m_to});
    chk("b_timeout",   {31'h0, b_timeout},   {31'h0, m_to});
`endif
  end

  task automatic start_run(input logic [15:0] n);
    start = 1'b1; num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic v, input logic [19:0] d);
    in_valid = v; in_data = d;
    @(negedge clk);
  endtask

  task automatic ack();
    in_valid = 1'b0;
    sig_ack = 1'b1;
    @(negedge clk);
    sig_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with start and in_valid held high
    start = 1'b1; in_valid = 1'b1; num_samples = 16'd5; in_data = 20'h12345;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", {31'h0, a_in_ready}, 32'h0);
    chk("t1_sig_a", a_sig_out, 32'h00000000);
    chk("t1_sig_b", b_sig_out, 32'h80000000);
    chk("t1_valid", {31'h0, a_sig_valid}, 32'h0);

    // Two back-to-back samples
    start_run(16'd2);
    send(1'b1, 20'h00005);
    send(1'b1, 20'h00003);
    in_valid = 1'b0;
    chk("t2_sig_a", a_sig_out, 32'h00000009);
    chk("t2_sig_b", b_sig_out, 32'h09823B67);
    chk("t2_count", {16'h0, a_sample_count}, 32'd2);
    chk("t2_valid", {31'h0, a_sig_valid}, 32'h1);
    ack();
    chk("t2_idle_busy", {31'h0, a_busy}, 32'h0);

    // Feedback path from the high seed
    start_run(16'd1);
    send(1'b1, 20'h00000);
    in_valid = 1'b0;
    chk("t3_sig_b", b_sig_out, 32'h04C11DB7);
    chk("t3_sig_a", a_sig_out, 32'h00000000);
    ack();

    // Gapped valid, start pulses ignored in COLLECT and DONE
    start_run(16'd3);
    send(1'b1, 20'h00005);
    start = 1'b1;
    send(1'b0, 20'(($urandom)));
    start = 1'b0;
    send(1'b0, 20'(($urandom)));
    send(1'b1, 20'h00003);
    send(1'b0, 20'(($urandom)));
    send(1'b1, 20'h00001);
    chk("t4_sig_a", a_sig_out, 32'h00000013);
    chk("t4_count", {16'h0, a_sample_count}, 32'd3);
    start = 1'b1;
    send(1'b1, 20'h00007);
    start = 1'b0;
    send(1'b0, 20'h00000);
    chk("t4_done_ready", {31'h0, a_in_ready}, 32'h0);
    chk("t4_done_sig", a_sig_out, 32'h00000013);
    chk("t4_done_valid", {31'h0, a_sig_valid}, 32'h1);
    start = 1'b1;
    ack();
    start = 1'b0;
    @(negedge clk);
    chk("t4_ack_start_busy", {31'h0, a_busy}, 32'h0);

    // Zero-length run
    start_run(16'd0);
    chk("t5_valid", {31'h0, a_sig_valid}, 32'h1);
    chk("t5_sig_b", b_sig_out, 32'h80000000);
    chk("t5_in_ready", {31'h0, a_in_ready}, 32'h0);
    ack();

    // Asynchronous reset mid-run
    start_run(16'd4);
    send(1'b1, 20'h00009);
    in_data = 20'h00002;
    #2 rst_n = 1'b0;
    #1;
    chk("t5r_sig_a", a_sig_out, 32'h00000000);
    chk("t5r_sig_b", b_sig_out, 32'h80000000);
    chk("t5r_busy", {31'h0, a_busy}, 32'h0);
    chk("t5r_count", {16'h0, a_sample_count}, 32'h0);
    chk("t5r_in_ready", {31'h0, a_in_ready}, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef EXPR_MISR_TIMEOUT_EN
    // Idle timeout after one sample
    begin
      int waited;
      waited = 0;
      start_run(16'd4);
      send(1'b1, 20'h00006);
      in_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        waited++;
        if (a_sig_valid) break;
      end
      chk("t6_wait", 32'(waited), 32'd255);
      chk("t6_timeout", {31'h0, a_timeout}, 32'h1);
      chk("t6_count", {16'h0, a_sample_count}, 32'd1);
      chk("t6_sig_a", a_sig_out, 32'h00000006);
      ack();
      chk("t6_clear", {31'h0, a_timeout}, 32'h0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
